// File: rtl/eeprom_rw_ctrl_if.sv
// Command/response bundle between the EEPROM test sequencer
// and the I2C byte driver.
interface eeprom_rw_ctrl_if;
  logic        i2c_exec;
  logic        bit_ctrl;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;

  modport master (
    output i2c_exec, bit_ctrl, i2c_rh_wl,
    output i2c_addr, i2c_data_w,
    input  i2c_data_r, i2c_done
  );

  modport slave (
    input  i2c_exec, bit_ctrl, i2c_rh_wl,
    input  i2c_addr, i2c_data_w,
    output i2c_data_r, i2c_done
  );
endinterface

// File: rtl/eeprom_rw_ctrl.sv
// EEPROM write/read-back test sequencer driving the I2C byte
// driver through its exec/done handshake.
module eeprom_rw_ctrl #(
  parameter int          NUM_BYTES = 256,
  parameter logic        BIT_CTRL  = 1'b1,
  parameter logic [7:0]  PATTERN   = 8'h5A,
  parameter logic [15:0] WR_GAP    = 16'd5000,
  parameter logic [15:0] TIMEOUT   = 16'd20000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  eeprom_rw_ctrl_if.master         bus,
  output logic                     busy,
  output logic                     rw_done,
  output logic                     rw_pass,
  output logic                     timeout_err,
  output logic [15:0]              err_addr
);

  localparam logic [16:0] LAST = 17'(NUM_BYTES - 1);
  localparam logic [16:0] GAP  = {1'b0, WR_GAP};

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, WR_GAP_S,
    RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [16:0] addr_q, addr_d;
  logic [15:0] gcnt_q, gcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        fail_q, fail_d;
  logic        exec_q, exec_d;
  logic        rh_wl_q, rh_wl_d;
  logic [15:0] ia_q, ia_d;
  logic [7:0]  dw_q, dw_d;
  logic        busy_d, done_d, pass_d, tmo_d;
  logic [15:0] ea_d;

  logic last, gap_end, tmo_hit, mism;

  assign last    = (addr_q == LAST);
  assign gap_end = ({1'b0, gcnt_q} + 17'd1) >= GAP;
  assign tmo_hit = (tcnt_q == TIMEOUT - 16'd1);
  assign mism    = bus.i2c_data_r != (addr_q[7:0] ^ PATTERN);

  assign bus.i2c_exec   = exec_q;
  assign bus.bit_ctrl   = BIT_CTRL;
  assign bus.i2c_rh_wl  = rh_wl_q;
  assign bus.i2c_addr   = ia_q;
  assign bus.i2c_data_w = dw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      gcnt_q      <= '0;
      tcnt_q      <= '0;
      fail_q      <= 1'b0;
      exec_q      <= 1'b0;
      rh_wl_q     <= 1'b0;
      ia_q        <= '0;
      dw_q        <= '0;
      busy        <= 1'b0;
      rw_done     <= 1'b0;
      rw_pass     <= 1'b0;
      timeout_err <= 1'b0;
      err_addr    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      gcnt_q      <= gcnt_d;
      tcnt_q      <= tcnt_d;
      fail_q      <= fail_d;
      exec_q      <= exec_d;
      rh_wl_q     <= rh_wl_d;
      ia_q        <= ia_d;
      dw_q        <= dw_d;
      busy        <= busy_d;
      rw_done     <= done_d;
      rw_pass     <= pass_d;
      timeout_err <= tmo_d;
      err_addr    <= ea_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE:
        if (start) state_d = WR_REQ;
      WR_REQ:
        state_d = WR_WAIT;
      WR_WAIT:
        if (bus.i2c_done)  state_d = WR_GAP_S;
        else if (tmo_hit)  state_d = DONE;
      WR_GAP_S:
        if (gap_end) state_d = last ? RD_REQ : WR_REQ;
      RD_REQ:
        state_d = RD_WAIT;
      RD_WAIT:
        if (bus.i2c_done)  state_d = last ? DONE : RD_REQ;
        else if (tmo_hit)  state_d = DONE;
      default:
        state_d = IDLE;
    endcase
  end

  // Output regs take their next value here; command fields are
  // loaded only on entry to a request state so they stay stable
  // from the exec strobe until done.
  always_comb begin
    addr_d  = addr_q;
    gcnt_d  = gcnt_q;
    tcnt_d  = tcnt_q;
    fail_d  = fail_q;
    exec_d  = 1'b0;
    rh_wl_d = rh_wl_q;
    ia_d    = ia_q;
    dw_d    = dw_q;
    busy_d  = busy;
    done_d  = rw_done;
    pass_d  = rw_pass;
    tmo_d   = timeout_err;
    ea_d    = err_addr;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          done_d = 1'b0;
          pass_d = 1'b0;
          tmo_d  = 1'b0;
          ea_d   = '0;
          fail_d = 1'b0;
          busy_d = 1'b1;
          addr_d = '0;
        end
      end
      WR_REQ, RD_REQ:
        tcnt_d = '0;
      WR_WAIT: begin
        if (bus.i2c_done) begin
          gcnt_d = '0;
        end else if (tmo_hit) begin
          tmo_d  = 1'b1;
          pass_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      WR_GAP_S: begin
        if (gap_end) addr_d = last ? '0 : addr_q + 17'd1;
        else         gcnt_d = gcnt_q + 16'd1;
      end
      RD_WAIT: begin
        if (bus.i2c_done) begin
          if (mism && !fail_q) begin
            fail_d = 1'b1;
            ea_d   = addr_q[15:0];
          end
          if (last) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = !(fail_q || mism) && !timeout_err;
          end else begin
            addr_d = addr_q + 17'd1;
          end
        end else if (tmo_hit) begin
          tmo_d  = 1'b1;
          pass_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      default: ;
    endcase
    if (state_d == WR_REQ || state_d == RD_REQ) begin
      exec_d  = 1'b1;
      rh_wl_d = (state_d == RD_REQ);
      ia_d    = addr_d[15:0];
      if (state_d == WR_REQ) dw_d = addr_d[7:0] ^ PATTERN;
    end
  end

endmodule

// File: tb/tb_eeprom_rw_ctrl.sv
// Directed bench for eeprom_rw_ctrl with a small driver+EEPROM
// model that can hang or corrupt read data.
module tb_eeprom_rw_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, rw_done, rw_pass, timeout_err;
  logic [15:0] err_addr;

  eeprom_rw_ctrl_if bus();

  eeprom_rw_ctrl #(
    .NUM_BYTES(4), .PATTERN(8'h5A),
    .WR_GAP(16'd10), .TIMEOUT(16'd50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .rw_done(rw_done), .rw_pass(rw_pass),
    .timeout_err(timeout_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // driver + EEPROM model
  logic        model_done = 1'b0;
  logic        inj_done = 1'b0;
  logic [7:0]  model_rd = 8'h00;
  logic        hang = 1'b0;
  logic [3:0]  corrupt = 4'b0000;
  logic [7:0]  mem [4];
  logic        pend = 1'b0, p_rd = 1'b0, wdone_vld = 1'b0;
  logic [15:0] p_addr = '0;
  int          cnt = 0, cyc = 0, wdone_cyc = 0;
  int          exec_cnt = 0, rd_exec_cnt = 0, wd_cnt = 0;
  int          min_gap = 1000;
  logic [24:0] log_q [$];

  assign bus.i2c_done   = model_done | inj_done;
  assign bus.i2c_data_r = model_rd;

  always @(negedge clk) begin
    cyc++;
    model_done = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          pend = 1'b0;
          model_done = 1'b1;
          if (p_rd)
            model_rd = corrupt[p_addr[1:0]] ? 8'h00 : mem[p_addr[1:0]];
          else begin
            wd_cnt++;
            wdone_cyc = cyc;
            wdone_vld = 1'b1;
          end
        end else cnt--;
      end
      if (bus.i2c_exec) begin
        exec_cnt++;
        log_q.push_back({bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w});
        if (bus.i2c_rh_wl) begin
          rd_exec_cnt++;
          wdone_vld = 1'b0;
        end else if (wdone_vld && (cyc - wdone_cyc) < min_gap) begin
          min_gap = cyc - wdone_cyc;
        end
        if (!hang) begin
          pend = 1'b1;
          cnt = 2;
          p_rd = bus.i2c_rh_wl;
          p_addr = bus.i2c_addr;
          if (!bus.i2c_rh_wl) mem[bus.i2c_addr[1:0]] = bus.i2c_data_w;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] wexp [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (rw_done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, rw_done}, 32'd1);
  endtask

  task automatic check_log(input string tag, input int base);
    logic [24:0] e;
    for (int i = 0; i < 8; i++) begin
      e = (base + i < log_q.size()) ? log_q[base + i] : 25'h1FFFFFF;
      if (i < 4)
        chk($sformatf("%s_wr%0d", tag, i), {7'd0, e},
            {7'd0, 1'b0, 16'(i), wexp[i]});
      else
        chk($sformatf("%s_rd%0d", tag, i - 4), {15'd0, e[24:8]},
            {15'd0, 1'b1, 16'(i - 4)});
    end
  endtask

  int n, e0, r0, w0, l0;

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, rw_done}, 32'd0);
    chk("rst_pass", {31'd0, rw_pass}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("rst_err_addr", {16'd0, err_addr}, 32'd0);
    chk("rst_exec", {31'd0, bus.i2c_exec}, 32'd0);
    chk("bit_ctrl", {31'd0, bus.bit_ctrl}, 32'd1);
    rst_n = 1'b1;
    tick();

    // clean pass
    e0 = exec_cnt; l0 = log_q.size();
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("clean_done", n);
    chk("clean_pass", {31'd0, rw_pass}, 32'd1);
    chk("clean_err_addr", {16'd0, err_addr}, 32'd0);
    chk("clean_tmo", {31'd0, timeout_err}, 32'd0);
    chk("clean_busy", {31'd0, busy}, 32'd0);
    chk("clean_execs", exec_cnt - e0, 32'd8);
    check_log("clean", l0);

    // corrupt reads at addr 2 and 3
    corrupt = 4'b1100;
    pulse_start();
    wait_done("corr_done", n);
    chk("corr_pass", {31'd0, rw_pass}, 32'd0);
    chk("corr_err_addr", {16'd0, err_addr}, 32'd2);
    chk("corr_tmo", {31'd0, timeout_err}, 32'd0);
    corrupt = 4'b0000;

    // driver never answers the first write
    hang = 1'b1;
    e0 = exec_cnt;
    pulse_start();
    wait_done("tmo_done", n);
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    chk("tmo_pass", {31'd0, rw_pass}, 32'd0);
    chk("tmo_execs", exec_cnt - e0, 32'd1);
    chk("tmo_latency", {31'd0, n >= 48 && n <= 52}, 32'd1);
    hang = 1'b0;

    // stray start and done pulses mid-run
    e0 = exec_cnt; w0 = wd_cnt; r0 = rd_exec_cnt;
    pulse_start();
    for (int i = 0; i < 500 && wd_cnt < w0 + 1; i++) tick();
    chk("stray_wr_seen", {31'd0, wd_cnt >= w0 + 1}, 32'd1);
    tick();
    tick();
    pulse_start();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    for (int i = 0; i < 500 && rd_exec_cnt < r0 + 1; i++) tick();
    chk("stray_rd_seen", {31'd0, rd_exec_cnt >= r0 + 1}, 32'd1);
    tick();
    pulse_start();
    wait_done("stray_done", n);
    chk("stray_execs", exec_cnt - e0, 32'd8);
    chk("stray_pass", {31'd0, rw_pass}, 32'd1);
    chk("stray_err_addr", {16'd0, err_addr}, 32'd0);

    // asynchronous reset in the read pass
    r0 = rd_exec_cnt;
    pulse_start();
    for (int i = 0; i < 500 && rd_exec_cnt < r0 + 2; i++) tick();
    chk("rst_rd_seen", {31'd0, rd_exec_cnt >= r0 + 2}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rh_wl", {31'd0, bus.i2c_rh_wl}, 32'd0);
    chk("arst_addr", {16'd0, bus.i2c_addr}, 32'd0);
    chk("arst_data_w", {24'd0, bus.i2c_data_w}, 32'd0);
    e0 = exec_cnt;
    tick();
    tick();
    tick();
    chk("arst_no_exec", exec_cnt - e0, 32'd0);
    rst_n = 1'b1;
    tick();
    e0 = exec_cnt; l0 = log_q.size();
    pulse_start();
    wait_done("post_rst_done", n);
    chk("post_rst_pass", {31'd0, rw_pass}, 32'd1);
    chk("post_rst_execs", exec_cnt - e0, 32'd8);

    // restart from DONE
    l0 = log_q.size();
    pulse_start();
    chk("again_done_low", {31'd0, rw_done}, 32'd0);
    chk("again_busy", {31'd0, busy}, 32'd1);
    wait_done("again_done", n);
    chk("again_pass", {31'd0, rw_pass}, 32'd1);
    check_log("again", l0);

    chk("min_wr_gap", {31'd0, min_gap >= 11}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
